// File: rtl/adder_32_bit_pkg.sv
// Datapath adder constants: operand width and carry-lookahead group geometry.
package adder_32_bit_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned GRP_W = 4;
   localparam int unsigned N_GRP = WIDTH / GRP_W;

endpackage

// File: rtl/cla_4_bit.sv
// 4-bit carry-lookahead group: internal carries are flattened sum-of-products,
// and the group generate/propagate feed the second-level lookahead.
module cla_4_bit
   import adder_32_bit_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] b,
   input  logic             ci,
   output logic [GRP_W-1:0] s,
   output logic             g,
   output logic             p
);

   logic [GRP_W-1:0] gen;
   logic [GRP_W-1:0] prop;
   logic [GRP_W-1:0] c;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Group G/P must not depend on ci, or the second level would form a loop.
   assign g = gen[3]
            | (prop[3] & gen[2])
            | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
   assign p = &prop;

   always_comb begin
      c[0] = ci;
      c[1] = gen[0] | (prop[0] & ci);
      c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
      c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
           | (prop[2] & prop[1] & prop[0] & ci);
      s    = prop ^ c;
   end

endmodule

// File: rtl/adder_32_bit.sv
// 32-bit two's-complement adder: eight CLA groups, a second-level lookahead,
// signed overflow, and a registered copy of sum/cout/ovf for the ALU result path.
module adder_32_bit
   import adder_32_bit_pkg::*;
(
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q
);

   logic [N_GRP-1:0] grp_g;
   logic [N_GRP-1:0] grp_p;
   logic [N_GRP:0]   c;
   logic             c_next;
   logic             p_chain;

   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
      cla_4_bit u_cla (
         .a  (a[gi*GRP_W +: GRP_W]),
         .b  (b[gi*GRP_W +: GRP_W]),
         .ci (c[gi]),
         .s  (sum[gi*GRP_W +: GRP_W]),
         .g  (grp_g[gi]),
         .p  (grp_p[gi])
      );
   end

   // Each group carry is expanded to a flat G/P product sum, so no carry
   // ever ripples from one group into the next.
   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      c       = '0;
      c_next  = 1'b0;
      p_chain = 1'b0;
      c[0]    = cin;
      for (int k = 0; k < N_GRP; k++) begin
         c_next  = grp_g[k];
         p_chain = grp_p[k];
         for (int j = k - 1; j >= 0; j--) begin
            c_next  = c_next | (p_chain & grp_g[j]);
            p_chain = p_chain & grp_p[j];
         end
         c[k+1] = c_next | (p_chain & cin);
      end
   end

   assign cout = c[N_GRP];
   assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      sum_d  = sum;
      cout_d = cout;
      ovf_d  = ovf;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge value regardless of block evaluation order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_adder_32_bit.sv
// Directed and random checks of adder_32_bit: combinational results checked
// immediately, registered results popped from a scoreboard one edge later.
module tb_adder_32_bit;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        clr_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic [31:0] sum_q;
   logic        cout_q;
   logic        ovf_q;

   int   n_tests;
   int   n_fail;
   exp_t sb_q[$];

   adder_32_bit dut (
      .clk    (clk),
      .clr_n  (clr_n),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive operands, check the combinational outputs, queue the expected
   // registered value, then check it after the next rising edge.
   task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tc, input logic [31:0] e_sum, input logic e_cout,
                       input logic e_ovf);
      exp_t e;
      a   = ta;
      b   = tb_v;
      cin = tc;
      #1;
      check({tag, " sum"},  sum,  e_sum);
      check({tag, " cout"}, {31'b0, cout}, {31'b0, e_cout});
      check({tag, " ovf"},  {31'b0, ovf},  {31'b0, e_ovf});
      e.sum  = e_sum;
      e.cout = e_cout;
      e.ovf  = e_ovf;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, " sum_q"},  sum_q,  e.sum);
         check({tag, " cout_q"}, {31'b0, cout_q}, {31'b0, e.cout});
         check({tag, " ovf_q"},  {31'b0, ovf_q},  {31'b0, e.ovf});
      end
   endtask

   // Reference: 33-bit unsigned add, overflow from operand/result sign bits.
   task automatic step_model(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic tc);
      logic [32:0] full;
      logic        o;
      full = {1'b0, ta} + {1'b0, tb_v} + {32'b0, tc};
      o    = (ta[31] == tb_v[31]) && (full[31] != ta[31]);
      step(tag, ta, tb_v, tc, full[31:0], full[32], o);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clr_n   = 1'b0;
      a       = '0;
      b       = '0;
      cin     = 1'b0;
      #1;
      check("reset sum_q",  sum_q, 32'h0);
      check("reset cout_q", {31'b0, cout_q}, 32'h0);
      check("reset ovf_q",  {31'b0, ovf_q},  32'h0);
      @(posedge clk);
      #2;
      clr_n = 1'b1;
      @(posedge clk);
      #1;

      step("add4",     32'h0444_4444, 32'h0444_4444, 1'b0, 32'h0888_8888, 1'b0, 1'b0);
      step("add8",     32'h0811_1111, 32'h0811_1111, 1'b0, 32'h1022_2222, 1'b0, 1'b0);
      step("chain",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      step("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      step("neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      step("sub5_7",   32'h0000_0005, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      step("grp_edge", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0);
      step("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      step("sub_eq",   32'h1234_5678, 32'hEDCB_A987, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

      for (int i = 0; i < 12; i++) begin
         step_model($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      // Load a nonzero registered value, then clear between clock edges.
      step("pre_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      #2;
      clr_n = 1'b0;
      #1;
      check("clr sum_q",    sum_q, 32'h0);
      check("clr cout_q",   {31'b0, cout_q}, 32'h0);
      check("clr ovf_q",    {31'b0, ovf_q},  32'h0);
      check("clr sum comb", sum,   32'h2345_6789);
      @(posedge clk);
      #1;
      check("clr hold sum_q", sum_q, 32'h0);
      #2;
      clr_n = 1'b1;
      #1;
      check("rel pre-edge sum_q", sum_q, 32'h0);
      @(posedge clk);
      #1;
      check("rel capture sum_q",  sum_q, 32'h2345_6789);
      check("rel capture cout_q", {31'b0, cout_q}, 32'h0);

      step("post_rst", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
